// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: fetches one instruction per
// execute cycle over a req/ack handshake, resolves the next PC from the
// decoder's branch/link outputs, and owns the carry flag and link write.
module pc_fetch_unit #(
  parameter int unsigned     ADDR_W   = 32,
  parameter int unsigned     INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic               o_imem_req,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic               i_imem_ack,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_instr_vld,
  input  logic               i_exec_done,
  input  logic [1:0]         i_branch,
  input  logic               i_link,
  input  logic [3:0]         i_fcode,
  input  logic [ADDR_W-1:0]  i_rs_val,
  input  logic [ADDR_W-1:0]  i_imm_off,
  input  logic               i_carry_in,
  input  logic               i_carry_we,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_ra_we,
  output logic [ADDR_W-1:0]  o_ra_wdata
);

  localparam int unsigned MSB = ADDR_W - 1;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_REG  = 2'b01;
  localparam logic [1:0] BR_CY   = 2'b10;
  localparam logic [1:0] BR_UNC  = 2'b11;

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_WAIT  = 2'b01,
    S_EXEC  = 2'b10
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_imem_req;
  logic                 r_instr_vld;
  logic [INSTR_W-1:0]   r_instr;
  logic [ADDR_W-1:0]    r_pc;
  logic                 r_carry;
  logic                 r_ra_we;
  logic [ADDR_W-1:0]    r_ra_wdata;

  logic                 w_req_nxt;
  logic                 w_vld_nxt;
  logic                 w_instr_load;
  logic                 w_pc_load;
  logic                 w_ra_we_nxt;
  logic [ADDR_W-1:0]    w_seq;
  logic [ADDR_W-1:0]    w_tgt;
  logic [ADDR_W-1:0]    w_raw_pc;
  logic [ADDR_W-1:0]    w_next_pc;
  logic                 w_link;

  assign w_seq     = r_pc + ADDR_W'(4);
  assign w_tgt     = w_seq + i_imm_off;
  assign w_next_pc = {w_raw_pc[MSB:2], 2'b00};
  assign w_link    = i_link && (i_branch == BR_UNC);

  // Next-PC resolution; carry-conditional branches see the flag before any same-cycle update
  always_comb begin
    w_raw_pc = w_seq;
    unique case (i_branch)
      BR_NONE: w_raw_pc = w_seq;
      BR_REG: begin
        unique case (i_fcode)
          4'b0000: w_raw_pc = i_rs_val;
          4'b0001: w_raw_pc = i_rs_val[MSB] ? w_tgt : w_seq;
          4'b0010: w_raw_pc = (i_rs_val == '0) ? w_tgt : w_seq;
          4'b0011: w_raw_pc = (i_rs_val != '0) ? w_tgt : w_seq;
          default: w_raw_pc = w_seq;
        endcase
      end
      BR_CY: begin
        unique case (i_fcode)
          4'b0010: w_raw_pc = r_carry ? w_tgt : w_seq;
          4'b0011: w_raw_pc = r_carry ? w_seq : w_tgt;
          default: w_raw_pc = w_seq;
        endcase
      end
      BR_UNC:  w_raw_pc = w_tgt;
      default: w_raw_pc = w_seq;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_FETCH;
    else       r_state <= w_state_nxt;
  end

  // FSM next state and next values of the registered handshake outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_req_nxt    = 1'b0;
    w_vld_nxt    = r_instr_vld;
    w_instr_load = 1'b0;
    w_pc_load    = 1'b0;
    w_ra_we_nxt  = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        w_state_nxt = S_WAIT;
        w_req_nxt   = 1'b1;
      end
      S_WAIT: begin
        w_req_nxt = 1'b1;
        if (i_imem_ack) begin
          w_instr_load = 1'b1;
          w_vld_nxt    = 1'b1;
          w_req_nxt    = 1'b0;
          w_state_nxt  = S_EXEC;
        end
      end
      S_EXEC: begin
        if (i_exec_done) begin
          w_pc_load   = 1'b1;
          w_vld_nxt   = 1'b0;
          w_req_nxt   = 1'b1;
          w_ra_we_nxt = w_link;
          w_state_nxt = S_WAIT;
        end
      end
      default: begin
        w_state_nxt = S_FETCH;
        w_vld_nxt   = 1'b0;
      end
    endcase
  end

  // Handshake, instruction, PC and link-write registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_imem_req  <= 1'b0;
      r_instr_vld <= 1'b0;
      r_instr     <= '0;
      r_pc        <= RESET_PC;
      r_ra_we     <= 1'b0;
      r_ra_wdata  <= '0;
    end else begin
      r_imem_req  <= w_req_nxt;
      r_instr_vld <= w_vld_nxt;
      r_ra_we     <= w_ra_we_nxt;
      if (w_instr_load) r_instr <= i_imem_rdata;
      if (w_pc_load) begin
        r_pc <= w_next_pc;
        if (w_ra_we_nxt) r_ra_wdata <= w_seq;
      end
    end
  end

  // Architectural carry flag, writable in any state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)           r_carry <= 1'b0;
    else if (i_carry_we) r_carry <= i_carry_in;
  end

  assign o_imem_req  = r_imem_req;
  assign o_imem_addr = r_pc;
  assign o_instr     = r_instr;
  assign o_instr_vld = r_instr_vld;
  assign o_pc        = r_pc;
  assign o_ra_we     = r_ra_we;
  assign o_ra_wdata  = r_ra_wdata;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a chained table of instructions with
// hand-computed next PCs, plus sequences for ignored events and reset.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_vld;
  logic        exec_done = 1'b0;
  logic [1:0]  branch = '0;
  logic        link = 1'b0;
  logic [3:0]  fcode = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] imm_off = '0;
  logic        carry_in = 1'b0;
  logic        carry_we = 1'b0;
  logic [31:0] pc;
  logic        ra_we;
  logic [31:0] ra_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  pc_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
    .o_instr(instr), .o_instr_vld(instr_vld),
    .i_exec_done(exec_done), .i_branch(branch), .i_link(link),
    .i_fcode(fcode), .i_rs_val(rs_val), .i_imm_off(imm_off),
    .i_carry_in(carry_in), .i_carry_we(carry_we),
    .o_pc(pc), .o_ra_we(ra_we), .o_ra_wdata(ra_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  branch;
    logic        link;
    logic [3:0]  fcode;
    logic [31:0] rs_val;
    logic [31:0] imm_off;
    logic        carry_we;
    logic        carry_in;
    logic [31:0] exp_pc;
    logic        exp_ra_we;
    logic [31:0] exp_ra_wdata;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [1:0] b, input logic l, input logic [3:0] f,
                              input logic [31:0] rs, input logic [31:0] imm,
                              input logic cwe, input logic cin, input logic [31:0] epc,
                              input logic era, input logic [31:0] erd);
    vec_t v;
    v.branch = b; v.link = l; v.fcode = f; v.rs_val = rs; v.imm_off = imm;
    v.carry_we = cwe; v.carry_in = cin; v.exp_pc = epc;
    v.exp_ra_we = era; v.exp_ra_wdata = erd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a fetch request; an expired bound shows up as a failed check
  task automatic wait_req(input string name);
    int cyc = 0;
    while (imem_req !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check({name, " req"}, 32'(imem_req), 32'd1);
  endtask

  // Fetch with an immediate ack, then execute one instruction and check the outcome
  task automatic run_instr(input string name, input vec_t v, input logic [31:0] word);
    wait_req(name);
    imem_ack = 1'b1; imem_rdata = word;
    tick();
    imem_ack = 1'b0; imem_rdata = '0;
    check({name, " vld"}, 32'(instr_vld), 32'd1);
    check({name, " instr"}, instr, word);
    branch = v.branch; link = v.link; fcode = v.fcode; rs_val = v.rs_val;
    imm_off = v.imm_off; carry_we = v.carry_we; carry_in = v.carry_in;
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0; carry_we = 1'b0; link = 1'b0; branch = '0;
    check({name, " pc"}, pc, v.exp_pc);
    check({name, " addr"}, imem_addr, v.exp_pc);
    check({name, " ra_we"}, 32'(ra_we), 32'(v.exp_ra_we));
    if (v.exp_ra_we) check({name, " ra_wdata"}, ra_wdata, v.exp_ra_wdata);
    check({name, " vld_clr"}, 32'(instr_vld), 32'd0);
    tick();
    if (v.exp_ra_we) check({name, " ra_we_pulse"}, 32'(ra_we), 32'd0);
  endtask

  initial begin
    vec_t v;
    //            br     lk    fc       rs_val         imm_off        cwe   cin   exp_pc         ra    ra_wdata
    vecs[0]  = mk(2'b00, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_0004, 1'b0, 32'h0);
    vecs[1]  = mk(2'b01, 1'b0, 4'b0000, 32'h100,       32'h0,         1'b0, 1'b0, 32'h0000_0100, 1'b0, 32'h0);
    vecs[2]  = mk(2'b11, 1'b1, 4'b0000, 32'h0,         32'h20,        1'b0, 1'b0, 32'h0000_0124, 1'b1, 32'h104);
    vecs[3]  = mk(2'b01, 1'b0, 4'b0010, 32'h0,         32'h10,        1'b0, 1'b0, 32'h0000_0138, 1'b0, 32'h0);
    vecs[4]  = mk(2'b01, 1'b0, 4'b0011, 32'h0,         32'h10,        1'b0, 1'b0, 32'h0000_013C, 1'b0, 32'h0);
    vecs[5]  = mk(2'b01, 1'b0, 4'b0001, 32'h8000_0000, 32'h40,        1'b0, 1'b0, 32'h0000_0180, 1'b0, 32'h0);
    vecs[6]  = mk(2'b01, 1'b0, 4'b0000, 32'h203,       32'h0,         1'b0, 1'b0, 32'h0000_0200, 1'b0, 32'h0);
    vecs[7]  = mk(2'b00, 1'b1, 4'b0000, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_0204, 1'b0, 32'h0);
    vecs[8]  = mk(2'b10, 1'b0, 4'b0010, 32'h0,         32'h100,       1'b1, 1'b1, 32'h0000_0208, 1'b0, 32'h0);
    vecs[9]  = mk(2'b10, 1'b0, 4'b0010, 32'h0,         32'h100,       1'b0, 1'b0, 32'h0000_030C, 1'b0, 32'h0);
    vecs[10] = mk(2'b10, 1'b0, 4'b0011, 32'h0,         32'h100,       1'b0, 1'b0, 32'h0000_0310, 1'b0, 32'h0);
    vecs[11] = mk(2'b10, 1'b0, 4'b0000, 32'h0,         32'h100,       1'b0, 1'b0, 32'h0000_0314, 1'b0, 32'h0);
    vecs[12] = mk(2'b01, 1'b0, 4'b0000, 32'h10,        32'h0,         1'b0, 1'b0, 32'h0000_0010, 1'b0, 32'h0);
    vecs[13] = mk(2'b11, 1'b0, 4'b0000, 32'h0,         32'hFFFF_FFF8, 1'b0, 1'b0, 32'h0000_000C, 1'b0, 32'h0);
    vecs[14] = mk(2'b01, 1'b0, 4'b0000, 32'hFFFF_FFFC, 32'h0,         1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0);
    vecs[15] = mk(2'b00, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0);
    vecs[16] = mk(2'b01, 1'b0, 4'b0111, 32'h0,         32'h40,        1'b0, 1'b0, 32'h0000_0004, 1'b0, 32'h0);
    vecs[17] = mk(2'b10, 1'b0, 4'b0011, 32'h0,         32'h20,        1'b1, 1'b0, 32'h0000_0008, 1'b0, 32'h0);
    vecs[18] = mk(2'b10, 1'b0, 4'b0011, 32'h0,         32'h20,        1'b0, 1'b0, 32'h0000_002C, 1'b0, 32'h0);
    vecs[19] = mk(2'b11, 1'b1, 4'b0000, 32'h0,         32'hFFFF_FFD4, 1'b0, 1'b0, 32'h0000_0004, 1'b1, 32'h30);
    vecs[20] = mk(2'b01, 1'b0, 4'b0011, 32'h5,         32'h7,         1'b0, 1'b0, 32'h0000_000C, 1'b0, 32'h0);

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst req", 32'(imem_req), 32'd0);
    check("rst pc", pc, 32'h0);
    check("rst instr", instr, 32'h0);
    check("rst vld", 32'(instr_vld), 32'd0);
    check("rst ra_we", 32'(ra_we), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // FETCH cycle, then a request held for two cycles without ack
    check("fetch req", 32'(imem_req), 32'd0);
    tick();
    check("wait1 req", 32'(imem_req), 32'd1);
    check("wait1 addr", imem_addr, 32'h0);
    tick();
    check("wait2 req", 32'(imem_req), 32'd1);
    check("wait2 addr", imem_addr, 32'h0);

    // Chained instruction table
    for (int i = 0; i < NV; i++)
      run_instr($sformatf("v%0d", i), vecs[i], 32'hA500_0000 + 32'(i));

    // exec_done in WAIT is ignored (pc stays 0xC)
    exec_done = 1'b1; branch = 2'b11; imm_off = 32'h100;
    tick();
    exec_done = 1'b0; branch = 2'b00;
    check("stray done pc", pc, 32'h0000_000C);
    check("stray done req", 32'(imem_req), 32'd1);
    check("stray done vld", 32'(instr_vld), 32'd0);

    // ack in EXEC ignored; carry written while in EXEC without exec_done
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_rdata = 32'hDEAD_BEEF; carry_we = 1'b1; carry_in = 1'b1;
    tick();
    imem_ack = 1'b0; carry_we = 1'b0;
    check("stray ack instr", instr, 32'h1234_5678);
    check("stray ack vld", 32'(instr_vld), 32'd1);
    check("stray ack req", 32'(imem_req), 32'd0);
    branch = 2'b10; fcode = 4'b0010; imm_off = 32'h40; exec_done = 1'b1;
    tick();
    exec_done = 1'b0; branch = 2'b00;
    check("exec carry bcy pc", pc, 32'h0000_0050);

    // Async reset while requesting, with an ack pending
    check("pre-rst req", 32'(imem_req), 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0000;
    rst = 1'b1;
    #1;
    check("mid rst req", 32'(imem_req), 32'd0);
    check("mid rst pc", pc, 32'h0);
    check("mid rst vld", 32'(instr_vld), 32'd0);
    check("mid rst instr", instr, 32'h0);
    tick();
    imem_ack = 1'b0;
    rst = 1'b0;
    check("post rst fetch req", 32'(imem_req), 32'd0);
    tick();
    check("post rst req", 32'(imem_req), 32'd1);
    check("post rst addr", imem_addr, 32'h0);
    check("post rst vld", 32'(instr_vld), 32'd0);
    // Carry was cleared by reset, so bcy falls through
    v = mk(2'b10, 1'b0, 4'b0010, 32'h0, 32'h40, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 32'h0);
    run_instr("post rst bcy", v, 32'h5A5A_0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
